// File: rtl/key_sched_ctrl.sv
// +--------------------------------------------------------------------------+
// | key_sched_ctrl: PRESENT-style round-key scheduler, valid/ready round keys |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_sched_ctrl #(
   parameter int KEY_W      = 80,
   parameter int RK_W       = 64,
   parameter int NUM_ROUNDS = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_valid,
   output logic             key_ready,
   output logic [RK_W-1:0]  rk_out,
   output logic [5:0]       rk_round,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic             rk_last,
   input  logic             abort,
   output logic             busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS + 1);

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [5:0]       rnd_q, rnd_d;
   logic [RK_W-1:0]  rk_out_q, rk_out_d;
   logic [5:0]       rk_round_q, rk_round_d;
   logic             rk_valid_q, rk_valid_d;
   logic             rk_last_q, rk_last_d;
   logic             busy_q, busy_d;
   logic             key_ready_q, key_ready_d;
   logic             emit_d;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
      endcase
   endfunction

   // Rotate left by 61, substitute the top nibble, then fold the round index in.
   function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       i);
      logic [KEY_W-1:0] r;
      r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
      r[KEY_W-1:KEY_W-4] = sbox(r[KEY_W-1:KEY_W-4]);
      r[19:15] = r[19:15] ^ i;
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      rnd_d   = rnd_q;
      case (state_q)
         IDLE: begin
            if (!abort && key_valid) begin
               key_d   = key_in;
               rnd_d   = 6'd1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (rk_ready) begin
               if (rnd_q == LAST_RND) begin
                  state_d = IDLE;
               end else begin
                  key_d = key_update(key_q, rnd_q[4:0]);
                  rnd_d = rnd_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next-state view so they change with the state.
      emit_d      = (state_d == EMIT);
      rk_valid_d  = emit_d;
      busy_d      = emit_d;
      key_ready_d = !emit_d;
      rk_out_d    = emit_d ? key_d[KEY_W-1 -: RK_W] : '0;
      rk_round_d  = emit_d ? rnd_d : 6'd0;
      rk_last_d   = emit_d && (rnd_d == LAST_RND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         rnd_q       <= 6'd0;
         rk_out_q    <= '0;
         rk_round_q  <= 6'd0;
         rk_valid_q  <= 1'b0;
         rk_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         key_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         rnd_q       <= rnd_d;
         rk_out_q    <= rk_out_d;
         rk_round_q  <= rk_round_d;
         rk_valid_q  <= rk_valid_d;
         rk_last_q   <= rk_last_d;
         busy_q      <= busy_d;
         key_ready_q <= key_ready_d;
      end
   end

   assign key_ready = key_ready_q;
   assign rk_out    = rk_out_q;
   assign rk_round  = rk_round_q;
   assign rk_valid  = rk_valid_q;
   assign rk_last   = rk_last_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_W, default 80, master/working key width in bits.
REQ-002 The block SHALL have parameter RK_W, default 64, round-key width in bits; round key = working key[KEY_W-1:KEY_W-RK_W].
REQ-003 The block SHALL have parameter NUM_ROUNDS, default 31, cipher rounds; round keys issued = NUM_ROUNDS+1.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port key_in, input, KEY_W bits: master key.
REQ-007 The block SHALL have port key_valid, input, 1 bit: key_in valid.
REQ-008 The block SHALL have port key_ready, output, 1 bit: block can accept a master key.
REQ-009 The block SHALL have port rk_out, output, RK_W bits: current round key.
REQ-010 The block SHALL have port rk_round, output, 6 bits: index of rk_out, 1..NUM_ROUNDS+1.
REQ-011 The block SHALL have port rk_valid, output, 1 bit: rk_out/rk_round/rk_last valid.
REQ-012 The block SHALL have port rk_ready, input, 1 bit: consumer accepts round key.
REQ-013 The block SHALL have port rk_last, output, 1 bit: rk_out is the final round key.
REQ-014 The block SHALL have port abort, input, 1 bit: cancel current schedule.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever not in IDLE.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and EMIT.
REQ-017 In IDLE: key_ready=1, rk_valid=0, busy=0.
REQ-018 In IDLE, key_valid=1 SHALL load key_in into working key, set round counter to 1, and enter EMIT next cycle.
REQ-019 In EMIT: key_ready=0, busy=1, rk_valid=1, rk_out=working key top RK_W bits, rk_round=round counter.
REQ-020 rk_last SHALL be 1 iff EMIT and round counter = NUM_ROUNDS+1.
REQ-021 Outputs in EMIT SHALL hold stable while rk_ready=0; no internal state change.
REQ-022 A transfer SHALL occur on a cycle with rk_valid=1 and rk_ready=1.
REQ-023 On a transfer with rk_last=0: working key <= update(working key, round counter); round counter +1; stay in EMIT. Next key is visible the following cycle, giving at most 1 key per cycle (back-to-back with rk_ready held high).
REQ-024 On a transfer with rk_last=1: return to IDLE; working key is kept but is not observable.
REQ-025 update(k,i), for KEY_W=80, SHALL compute, in this order: k <= k rotated left 61; k[79:76] <= S(k[79:76]); k[19:15] <= k[19:15] XOR i[4:0].
REQ-026 The S-box S SHALL map 0..F to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-027 abort=1 in EMIT SHALL force IDLE next cycle with rk_valid=0, overriding a simultaneous transfer.
REQ-028 abort=1 in IDLE SHALL have priority over key_valid; the key is not accepted.
REQ-029 key_valid while in EMIT SHALL be ignored (key_ready=0); no queuing.
REQ-030 Round counter SHALL never exceed NUM_ROUNDS+1; no wrap.

Reset
REQ-031 rst=1 SHALL immediately set state=IDLE, round counter=0, working key=0, rk_out=0, rk_round=0, rk_valid=0, rk_last=0, busy=0, key_ready=1 (post-reset).
REQ-032 rst asserted mid-schedule SHALL discard the schedule; after deassertion the block waits in IDLE for a new key.

Verification
REQ-033 Key=0, rk_ready=1 always -> rk_round 1,2,3 give rk_out 0x0000000000000000, 0xC000000000000000, 0x5000180000000001; 32 consecutive transfers; rk_last only on round 32; then key_ready=1.
REQ-034 Same key, rk_ready toggled randomly -> identical 32-key sequence; rk_out/rk_round stable across stall cycles.
REQ-035 abort at rk_round=10 with rk_ready=1 -> rk_valid=0 next cycle, no round-11 key, key_ready=1; new key restarts at rk_round=1.
REQ-036 rst pulsed at rk_round=20 -> all outputs 0 asynchronously, key_ready=1 after release; key_valid during EMIT never accepted.
REQ-037 Key=all-ones -> rk_round=1 rk_out=0xFFFFFFFFFFFFFFFF; full sequence matches the PRESENT-80 reference model.
